// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL feedback-divider scheduler.
package dpll_pkg;
   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} sched_state_t;

   localparam int MIN_FACTOR_DEF = 2;

   localparam logic LF_DIR_DN = 1'b0;
   localparam logic LF_DIR_UP = 1'b1;
endpackage

// File: rtl/div_counter.sv
// Divide counter and registered divided clock; a pending factor is loaded
// only on the last cycle of a period so no runt period can occur.
module div_counter #(
   parameter int CNT_W      = 8,
   parameter int DEF_FACTOR = 5
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_factor,
   output logic             clk_o,
   output logic             tick_o,
   output logic [CNT_W-1:0] div_factor
);
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_factor;
   logic             r_clk;
   logic [CNT_W:0]   w_half;
   logic             w_tick;

   // ceil(factor/2) computed one bit wider so factor 2^CNT_W-1 cannot overflow
   assign w_half = ({1'b0, r_factor} + (CNT_W+1)'(1)) >> 1;
   assign w_tick = (r_cnt == (r_factor - CNT_W'(1)));

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_factor <= CNT_W'(DEF_FACTOR);
         r_clk    <= 1'b0;
      end else begin
         r_clk <= ({1'b0, r_cnt} < w_half);
         if (w_tick) begin
            r_cnt <= '0;
            if (load_en) r_factor <= load_factor;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign clk_o      = r_clk;
   assign tick_o     = w_tick;
   assign div_factor = r_factor;
endmodule

// File: rtl/div_factor_sched.sv
// Arbitrates software and loop-filter divide-factor requests, holding one
// accepted change until the next divided-period boundary.
module div_factor_sched
   import dpll_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int DEF_FACTOR = 5,
   parameter int MIN_FACTOR = MIN_FACTOR_DEF
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_factor,
   output logic             cfg_ready,
   input  logic             lf_valid,
   input  logic             lf_dir,
   output logic             lf_ready,
   output logic             clk_o,
   output logic             tick_o,
   output logic [CNT_W-1:0] div_factor,
   output logic             busy,
   output logic             err_o
);
   localparam logic [CNT_W-1:0] MAX_F = '1;
   localparam logic [CNT_W-1:0] MIN_F = CNT_W'(MIN_FACTOR);

   sched_state_t     r_state;
   logic [CNT_W-1:0] r_next;
   logic             r_err;
   logic             w_tick;
   logic [CNT_W-1:0] w_factor;
   logic             w_cfg_acc;
   logic             w_lf_acc;

   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] f,
                                                 input logic dir);
      if (dir == LF_DIR_UP) return (f == MAX_F) ? MAX_F : f + CNT_W'(1);
      else                  return (f <= MIN_F) ? MIN_F : f - CNT_W'(1);
   endfunction

   assign cfg_ready = (r_state == IDLE);
   assign lf_ready  = (r_state == IDLE) && !cfg_valid;
   assign busy      = (r_state == PEND);
   assign err_o     = r_err;
   assign w_cfg_acc = cfg_valid && cfg_ready;
   assign w_lf_acc  = lf_valid && lf_ready;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cfg_acc) begin
                  if (cfg_factor >= MIN_F) r_state <= PEND;
                  else                     r_err   <= 1'b1;
               end else if (w_lf_acc) begin
                  r_state <= PEND;
               end
            end
            PEND: if (w_tick) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Pending factor is pure data; it is only consumed while PEND is set
   always_ff @(posedge clk_in) begin
      if (w_cfg_acc)     r_next <= cfg_factor;
      else if (w_lf_acc) r_next <= sat_step(w_factor, lf_dir);
   end

   div_counter #(
      .CNT_W      (CNT_W),
      .DEF_FACTOR (DEF_FACTOR)
   ) u_div_counter (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .load_en     (r_state == PEND),
      .load_factor (r_next),
      .clk_o       (clk_o),
      .tick_o      (w_tick),
      .div_factor  (w_factor)
   );

   assign tick_o     = w_tick;
   assign div_factor = w_factor;
endmodule

// File: doc/div_factor_sched.md
# div_factor_sched

Runtime scheduler for the DPLL feedback divider. It arbitrates divide-factor change requests from a software configuration port and from the loop filter. It holds at most one accepted change pending and applies it only at a divided-period boundary, so `clk_o` never glitches or produces a runt period. It contains the divide counter and drives the divided clock consumed by the phase detector.

## Interface
Parameters:
- `CNT_W`, 8: width of the counter and of the factor.
- `DEF_FACTOR`, 5: factor loaded at reset. Must satisfy MIN_FACTOR ≤ DEF_FACTOR ≤ 2^CNT_W−1.
- `MIN_FACTOR`, 2: smallest legal factor.

Ports:
- `clk_in` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: software factor request.
- `cfg_factor` in CNT_W: requested absolute factor.
- `cfg_ready` out 1: software request accepted this cycle when `cfg_valid && cfg_ready`.
- `lf_valid` in 1: loop-filter step request.
- `lf_dir` in 1: 1 = factor+1, 0 = factor−1.
- `lf_ready` out 1: loop-filter request accepted this cycle when `lf_valid && lf_ready`.
- `clk_o` out 1: divided clock (registered).
- `tick_o` out 1: last cycle of the current divided period.
- `div_factor` out CNT_W: factor currently in effect.
- `busy` out 1: a change is pending.
- `err_o` out 1: sticky flag for an illegal cfg request.

## Operation
- Counter `cnt` runs 0 … `div_factor`−1, then wraps to 0.
- `tick_o` = (`cnt` == `div_factor`−1), combinational.
- `clk_o` is registered from the current `cnt`: high while `cnt` < ceil(`div_factor`/2), low otherwise. This gives 1 cycle of latency. For factor 5: 3 cycles high, 2 low. For factor 8: 4/4.
- FSM states:
  - IDLE: `cfg_ready` = 1; `lf_ready` = !`cfg_valid`. The software port has fixed priority.
  - PEND: both readies = 0; `busy` = 1.
- Transitions:
  - IDLE → PEND on an accepted cfg with `cfg_factor` ≥ MIN_FACTOR. Latch `next_factor` = `cfg_factor`.
  - IDLE → PEND on an accepted lf. Latch `next_factor` = `div_factor`±1, saturated to [MIN_FACTOR, 2^CNT_W−1].
  - IDLE stays IDLE on an accepted cfg with `cfg_factor` < MIN_FACTOR. Set `err_o`; `div_factor` is unchanged.
  - PEND → IDLE on a cycle with `tick_o` = 1. At that edge, `div_factor` ← `next_factor` and `cnt` ← 0.
- The lf step is always computed from the current `div_factor`. Only one change is ever pending.
- A saturated lf step that yields the same factor still goes through PEND. It costs one boundary and leaves the period unchanged.
- `err_o` is cleared only by reset.

## Timing
- Reset values: `cnt` = 0, `div_factor` = DEF_FACTOR, `clk_o` = 0, state = IDLE, `busy` = 0, `err_o` = 0, `cfg_ready` = 1.
- First rising `clk_in` edge after reset release: `clk_o` becomes 1.
- Request accepted in a cycle where `tick_o` = 1: the FSM enters PEND at that edge, and the change applies at the *following* boundary, not the current one.
- Request accepted mid-period: the new factor governs the period that starts after the current `tick_o`. The current period completes with the old factor. There is no partial or shortened period.
- Boundary to new-factor effect: `div_factor` updates at the edge ending the tick cycle. `clk_o` reflects the new duty cycle one cycle later, which is its normal registered latency.
- Both requesters valid in IDLE: only cfg is accepted; `lf_ready` = 0 in that cycle, and lf must hold its request.
- A request presented during PEND is not accepted. The requester holds valid until it sees ready.
- Reset asserted while in PEND: the pending change is discarded and all outputs return to their reset values immediately.

## Structure
- Shared package `dpll_pkg`:
  - state enum `sched_state_t {IDLE, PEND}`
  - MIN_FACTOR default constant
  - lf direction encoding constants
- One natural sub-module, `div_counter`. It holds the counter, the `clk_o` register, `tick_o`, and a load port (`load_en`, `load_factor`) sampled when `tick_o` = 1.
- The scheduler top holds the FSM, the arbitration, `next_factor`, the saturation logic and `err_o`.

## Test plan
- Reset with DEF_FACTOR = 5 and a 20 ns clock: `clk_o` period is 100 ns, 60 ns high / 40 ns low; `tick_o` pulses once every 5 cycles; `div_factor` = 5.
- `cfg_factor` = 8 accepted at `cnt` = 1:
  - `busy` = 1 until the next `tick_o`;
  - the current period remains 5 cycles;
  - subsequent periods are 8 cycles, 4 high / 4 low.
- `cfg_valid` and `lf_valid` asserted in the same IDLE cycle: `cfg_ready` = 1 and `lf_ready` = 0; cfg is applied. lf is accepted after PEND clears and takes the factor to cfg_factor±1.
- `lf_dir` = 0 repeatedly from factor 3: the factor goes to 2 and then stays at 2. `lf_dir` = 1 at 255 stays at 255.
- `cfg_factor` = 1: `err_o` rises and stays high; `div_factor` is unchanged; the state stays IDLE.
- `rst_n` pulsed low while in PEND (pending factor 8): the change is discarded; after release `div_factor` = 5 and the period is 5 cycles.
